// File: rtl/irq_pkg.sv
// Purpose: shared types and constants for the vectored interrupt controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package irq_pkg;

   // Handshake FSM: wait for a winner, hold the request, one dead cycle after INA.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } irq_state_t;

   // Vector width: one extra bit above the line index so the NMI code fits.
   function automatic int vec_w(input int n_irq);
      return $clog2(n_irq) + 1;
   endfunction

   // NMI vector code: the first value past the last line index.
   function automatic int nmi_code(input int n_irq);
      return n_irq;
   endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Purpose: groups peripheral requests, core handshake and mask/status signals.
// Latency: n/a (wires only).
// Backpressure: INT is held until the core pulses INA.
interface interrupt_controller_if
   import irq_pkg::*;
#(
   parameter int N_IRQ = 8
) ();
   logic [N_IRQ-1:0]         irq;
   logic                     NMI;
   logic                     INTD;
   logic                     mask_we;
   logic [N_IRQ-1:0]         mask_wdata;
   logic                     INA;
   logic                     eoi;
   logic                     INT;
   logic [vec_w(N_IRQ)-1:0]  vec;
   logic [N_IRQ-1:0]         mask;
   logic [N_IRQ-1:0]         isr;
   logic                     nmi_active;

   // Peripherals + core side.
   modport master (
      output irq, NMI, INTD, mask_we, mask_wdata, INA, eoi,
      input  INT, vec, mask, isr, nmi_active
   );

   // Controller side.
   modport slave (
      input  irq, NMI, INTD, mask_we, mask_wdata, INA, eoi,
      output INT, vec, mask, isr, nmi_active
   );
endinterface

// File: rtl/irq_prio_enc.sv
// Purpose: fixed-priority encoder, lowest set index wins.
// Latency: combinational.
// Backpressure: none.
module irq_prio_enc #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   output logic          found,
   output logic [IW-1:0] index
);
   // Scan from the lowest-priority end so the lowest set index is written last.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            index = IW'(i);
         end
      end
   end
endmodule

// File: rtl/interrupt_controller.sv
// Purpose: vectored interrupt controller with masking, fixed priority, nesting and NMI.
// Latency: SYNC+1 clk from a source edge to INT=1.
// Backpressure: INT/vec held until INA; one idle cycle (ACK) before the next request.
module interrupt_controller
   import irq_pkg::*;
#(
   parameter int               N_IRQ     = 8,
   parameter logic [N_IRQ-1:0] EDGE_MASK = 8'hFF,
   parameter int               SYNC      = 2,
   parameter logic [N_IRQ-1:0] MASK_RST  = 8'hFF
) (
   input logic                   clk,
   input logic                   rst_n,
   interrupt_controller_if.slave bus
);
   localparam int             VW      = vec_w(N_IRQ);
   localparam int             IW      = VW - 1;
   localparam logic [VW-1:0]  NMI_VEC = VW'(nmi_code(N_IRQ));

   logic [SYNC-1:0]  irq_sr [N_IRQ];
   logic [SYNC-1:0]  nmi_sr;
   logic [N_IRQ-1:0] irq_s, irq_d, rise, pend_q, pend_w;
   logic             nmi_s, nmi_d, nmi_rise, nmi_pend, nmi_eff, nmi_elig;
   logic [N_IRQ-1:0] mask_q, isr_q, isr_set, isr_next, above, elig, line_sel;
   logic             nmi_act_q, nmi_set, nmi_next;
   logic             ina_ok, ina_nmi, ina_line;
   logic             isr_found, elig_found;
   logic [IW-1:0]    isr_idx, elig_idx;
   irq_state_t       state;
   logic             int_q;
   logic [VW-1:0]    vec_q;

   genvar g;
   generate
      for (g = 0; g < N_IRQ; g++) begin : g_sync
         // Per-line synchroniser chain.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) irq_sr[g] <= '0;
            else        irq_sr[g] <= {irq_sr[g][SYNC-2:0], bus.irq[g]};
         end
         assign irq_s[g] = irq_sr[g][SYNC-1];
      end
   endgenerate

   // NMI synchroniser chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) nmi_sr <= '0;
      else        nmi_sr <= {nmi_sr[SYNC-2:0], bus.NMI};
   end
   assign nmi_s = nmi_sr[SYNC-1];

   // Edge detect on synchronised values; the edge itself counts as pending so
   // the request leaves IDLE in the same cycle the edge is seen.
   assign rise     = irq_s & ~irq_d & EDGE_MASK;
   assign nmi_rise = nmi_s & ~nmi_d;
   assign pend_w   = (EDGE_MASK & (pend_q | rise)) | (~EDGE_MASK & irq_s);
   assign nmi_eff  = nmi_pend | nmi_rise;

   // Acknowledge decode; INA only counts while a request is outstanding.
   assign ina_ok   = (state == REQ) & bus.INA;
   assign ina_nmi  = ina_ok & (vec_q == NMI_VEC);
   assign ina_line = ina_ok & ~ina_nmi;
   assign line_sel = ina_line ? (N_IRQ'(1) << vec_q[IW-1:0]) : '0;

   // In-service after this cycle's INA; in IDLE this equals the live isr.
   assign isr_set = isr_q | line_sel;
   assign nmi_set = nmi_act_q | ina_nmi;

   irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_isr_enc (
      .req   (isr_set),
      .found (isr_found),
      .index (isr_idx)
   );

   // Nesting window: only lines strictly above the highest in-service line.
   always_comb begin
      above = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         above[i] = ~isr_found | (IW'(i) < isr_idx);
      end
   end

   assign elig     = pend_w & ~mask_q & {N_IRQ{~bus.INTD}} & above;
   assign nmi_elig = nmi_eff & ~nmi_act_q;

   irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_elig_enc (
      .req   (elig),
      .found (elig_found),
      .index (elig_idx)
   );

   // eoi retires NMI first, else the highest-priority in-service line.
   always_comb begin
      isr_next = isr_set;
      nmi_next = nmi_set;
      if (bus.eoi) begin
         if (nmi_set)        nmi_next = 1'b0;
         else if (isr_found) isr_next[isr_idx] = 1'b0;
      end
   end

   // Pending, edge history, mask and in-service state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_d     <= '0;
         nmi_d     <= 1'b0;
         pend_q    <= '0;
         nmi_pend  <= 1'b0;
         mask_q    <= MASK_RST;
         isr_q     <= '0;
         nmi_act_q <= 1'b0;
      end else begin
         irq_d     <= irq_s;
         nmi_d     <= nmi_s;
         pend_q    <= ((pend_q & ~line_sel) | rise) & EDGE_MASK;
         nmi_pend  <= (nmi_pend & ~ina_nmi) | nmi_rise;
         if (bus.mask_we) mask_q <= bus.mask_wdata;
         isr_q     <= isr_next;
         nmi_act_q <= nmi_next;
      end
   end

   // Request handshake FSM with registered INT and vec.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         int_q <= 1'b0;
         vec_q <= '0;
      end else begin
         case (state)
            IDLE: if (nmi_elig | elig_found) begin
               vec_q <= nmi_elig ? NMI_VEC : {1'b0, elig_idx};
               int_q <= 1'b1;
               state <= REQ;
            end
            REQ: if (bus.INA) begin
               int_q <= 1'b0;
               state <= ACK;
            end
            ACK: state <= IDLE;
            default: begin
               state <= IDLE;
               int_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.INT        = int_q;
   assign bus.vec        = vec_q;
   assign bus.mask       = mask_q;
   assign bus.isr        = isr_q;
   assign bus.nmi_active = nmi_act_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Purpose: self-checking bench for interrupt_controller, scoreboard of expected vectors.
// Latency: checks SYNC+1 request latency explicitly.
// Backpressure: exercises held requests, nesting, NMI hold-off and frozen vectors.
module tb_interrupt_controller;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_q[$];

   always #5 clk = ~clk;

   interrupt_controller_if #(.N_IRQ(N)) bus ();

   interrupt_controller #(
      .N_IRQ(N), .EDGE_MASK(8'hFE), .SYNC(2), .MASK_RST(8'hFF)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_mask(input logic [N-1:0] m);
      bus.mask_we = 1'b1; bus.mask_wdata = m;
      tick(1);
      bus.mask_we = 1'b0;
   endtask

   task automatic do_ina();
      bus.INA = 1'b1; tick(1); bus.INA = 1'b0;
   endtask

   task automatic do_eoi();
      bus.eoi = 1'b1; tick(1); bus.eoi = 1'b0;
   endtask

   task automatic pulse(input logic [N-1:0] m);
      bus.irq = bus.irq | m; tick(2); bus.irq = bus.irq & ~m;
   endtask

   task automatic pulse_nmi();
      bus.NMI = 1'b1; tick(2); bus.NMI = 1'b0;
   endtask

   // Bounded wait for INT, then score the vector against the queue head.
   task automatic expect_req(input string tag);
      int k = 0;
      int e;
      while (bus.INT !== 1'b1 && k < 20) begin tick(1); k++; end
      chk({tag, "_int"}, 32'(bus.INT), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk({tag, "_vec"}, 32'(bus.vec), 32'(e));
   endtask

   // INT must stay low for n cycles.
   task automatic quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         if (bus.INT === 1'b1) break;
         tick(1);
      end
      chk(tag, 32'(bus.INT), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      bus.irq = '0; bus.NMI = 1'b0; bus.INTD = 1'b0; bus.mask_we = 1'b0;
      bus.mask_wdata = '0; bus.INA = 1'b0; bus.eoi = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_int",  32'(bus.INT), 32'd0);
      chk("rst_vec",  32'(bus.vec), 32'd0);
      chk("rst_isr",  32'(bus.isr), 32'd0);
      chk("rst_nmi",  32'(bus.nmi_active), 32'd0);
      chk("rst_mask", 32'(bus.mask), 32'hFF);
      tick(2);
      rst_n = 1'b1;
      tick(1);

      // Priority and exact latency.
      set_mask(8'h00);
      exp_q.push_back(2); exp_q.push_back(5);
      bus.irq = 8'h24;
      tick(2);
      chk("lat_early", 32'(bus.INT), 32'd0);
      tick(1);
      chk("lat", 32'(bus.INT), 32'd1);
      bus.irq = '0;
      expect_req("prio");
      do_ina();
      chk("prio_isr", 32'(bus.isr), 32'h04);
      chk("prio_int_low", 32'(bus.INT), 32'd0);
      do_eoi();
      chk("prio_eoi", 32'(bus.isr), 32'h00);
      expect_req("prio2");
      do_ina();
      do_eoi();

      // Nesting.
      exp_q.push_back(4);
      pulse(8'h10);
      expect_req("nest4");
      do_ina();
      chk("nest_isr4", 32'(bus.isr), 32'h10);
      pulse(8'h40);
      quiet("nest_hold6", 8);
      exp_q.push_back(1);
      pulse(8'h02);
      expect_req("nest1");
      do_ina();
      chk("nest_isr41", 32'(bus.isr), 32'h12);
      do_eoi();
      chk("nest_eoi1", 32'(bus.isr), 32'h10);
      do_eoi();
      chk("nest_eoi2", 32'(bus.isr), 32'h00);
      exp_q.push_back(6);
      expect_req("nest6");
      do_ina();
      do_eoi();

      // NMI ignores INTD and mask; second NMI waits for eoi.
      bus.INTD = 1'b1;
      set_mask(8'hFF);
      exp_q.push_back(8);
      pulse_nmi();
      expect_req("nmi");
      do_ina();
      chk("nmi_act", 32'(bus.nmi_active), 32'd1);
      pulse_nmi();
      quiet("nmi_hold", 8);
      do_eoi();
      chk("nmi_eoi", 32'(bus.nmi_active), 32'd0);
      exp_q.push_back(8);
      expect_req("nmi2");
      do_ina();
      do_eoi();
      chk("nmi_done", 32'(bus.nmi_active), 32'd0);
      bus.INTD = 1'b0;
      set_mask(8'h00);

      // eoi with nothing in service.
      do_eoi();
      chk("eoi_idle", 32'(bus.isr), 32'h00);

      // Level line 0 re-requests while held.
      bus.irq[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(0);
         expect_req("lvl");
         do_ina();
         if (i < 2) do_eoi();
      end
      bus.irq[0] = 1'b0;
      tick(4);
      do_eoi();
      chk("lvl_isr", 32'(bus.isr), 32'h00);
      quiet("lvl_drop", 8);

      // Edge line 3 pulsed once gives one request.
      exp_q.push_back(3);
      pulse(8'h08);
      expect_req("edge3");
      do_ina();
      do_eoi();
      quiet("edge_once", 10);

      // Frozen vector.
      exp_q.push_back(3);
      pulse(8'h08);
      expect_req("frz");
      bus.irq[0] = 1'b1;
      set_mask(8'h08);
      tick(6);
      chk("frz_int", 32'(bus.INT), 32'd1);
      chk("frz_vec", 32'(bus.vec), 32'd3);
      exp_q.push_back(0);
      do_ina();
      chk("frz_ack_low", 32'(bus.INT), 32'd0);
      expect_req("frz_next");
      do_ina();
      bus.irq[0] = 1'b0;
      tick(4);
      do_eoi();
      chk("frz_eoi0", 32'(bus.isr), 32'h08);
      do_eoi();
      chk("frz_eoi3", 32'(bus.isr), 32'h00);

      // Asynchronous reset mid-REQ with a line in service.
      set_mask(8'h00);
      exp_q.push_back(4);
      pulse(8'h10);
      expect_req("pre_rst4");
      do_ina();
      exp_q.push_back(2);
      pulse(8'h04);
      expect_req("pre_rst2");
      #2 rst_n = 1'b0;
      #1;
      chk("arst_int",  32'(bus.INT), 32'd0);
      chk("arst_vec",  32'(bus.vec), 32'd0);
      chk("arst_isr",  32'(bus.isr), 32'd0);
      chk("arst_mask", 32'(bus.mask), 32'hFF);
      chk("arst_nmi",  32'(bus.nmi_active), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      set_mask(8'h00);
      quiet("arst_pend", 10);

      // INA outside REQ does nothing.
      do_ina();
      chk("ina_idle", 32'(bus.isr), 32'h00);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
